// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction-fetch controller. Sequences PC -> memory read ->
//               IF/ID delivery with stall, flush and misaligned-PC handling.
//               Optional last-fetch reuse is enabled by defining the macro
//               IFETCH_REUSE_EN; without it, every aligned fetch goes to
//               memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        pc_ready_o,
  output logic        misalign_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  localparam logic [31:0] C_NOP = 32'h0000_0000;

  logic [1:0]  r_state;
  logic [31:0] r_mem_addr;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_misalign;
  logic        r_flush_pend;

  logic        w_misaligned;
  logic        w_flush_any;
  logic        w_reuse_hit;
  logic [31:0] w_reuse_instr;
  logic        w_pc_ready;

  assign w_misaligned = |pc_i[1:0];
  // A flush raised in the same cycle as the ack must also discard the data.
  assign w_flush_any  = r_flush_pend | flush_i;

`ifdef IFETCH_REUSE_EN
  logic [31:0] r_last_addr;
  logic [31:0] r_last_instr;
  logic        r_reuse_vld;

  assign w_reuse_hit   = r_reuse_vld && (pc_i == r_last_addr);
  assign w_reuse_instr = r_last_instr;

  // Remember the last clean, aligned memory delivery for reuse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_addr  <= 32'h0;
      r_last_instr <= 32'h0;
      r_reuse_vld  <= 1'b0;
    end else if (r_state == S_WAIT && mem_ack_i && !w_flush_any) begin
      r_last_addr  <= r_mem_addr;
      r_last_instr <= mem_data_i;
      r_reuse_vld  <= 1'b1;
    end
  end
`else
  assign w_reuse_hit   = 1'b0;
  assign w_reuse_instr = C_NOP;
`endif

  // PC advance enable: only on a consumed/flushed delivery or a flush in WAIT.
  always_comb begin
    w_pc_ready = 1'b0;
    case (r_state)
      S_WAIT:    w_pc_ready = flush_i;
      S_DELIVER: w_pc_ready = flush_i | ~stall_i;
      default:   w_pc_ready = 1'b0;
    endcase
  end

  // Fetch FSM and delivered-instruction datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= 32'h0;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_flush_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_mem_addr <= pc_i;
          if (w_misaligned) begin
            r_instr       <= C_NOP;
            r_instr_valid <= 1'b1;
            r_misalign    <= 1'b1;
            r_state       <= S_DELIVER;
          end else if (w_reuse_hit) begin
            r_instr       <= w_reuse_instr;
            r_instr_valid <= 1'b1;
            r_misalign    <= 1'b0;
            r_state       <= S_DELIVER;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // The memory transaction always runs to its ack.
          if (mem_ack_i) begin
            r_flush_pend <= 1'b0;
            if (w_flush_any) begin
              r_state <= S_ISSUE;
            end else begin
              r_instr       <= mem_data_i;
              r_instr_valid <= 1'b1;
              r_misalign    <= 1'b0;
              r_state       <= S_DELIVER;
            end
          end else if (flush_i) begin
            r_flush_pend <= 1'b1;
          end
        end

        S_DELIVER: begin
          // Flush overrides stall; a stall holds everything as-is.
          if (flush_i || !stall_i) begin
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_state       <= S_ISSUE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o     = (r_state == S_WAIT);
  assign mem_addr_o    = r_mem_addr;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_instr_valid;
  assign misalign_o    = r_misalign;
  assign pc_ready_o    = w_pc_ready;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Directed self-checking bench for ifetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        pc_ready_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_ready_o    (pc_ready_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; pc_i = 32'h0; stall_i = 1'b0;
    flush_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    step(); step();
    chk("rst_req",      {31'h0, mem_req_o},     32'h0);
    chk("rst_valid",    {31'h0, instr_valid_o}, 32'h0);
    chk("rst_pcready",  {31'h0, pc_ready_o},    32'h0);
    chk("rst_misalign", {31'h0, misalign_o},    32'h0);
    chk("rst_instr",    instr_o,                32'h0);
    chk("rst_addr",     mem_addr_o,             32'h0);

    // Basic fetch at pc 0, ack in the second WAIT cycle.
    rst_i = 1'b0; start_i = 1'b1; pc_i = 32'h0;
    step();                                   // IDLE -> ISSUE
    chk("issue_req", {31'h0, mem_req_o}, 32'h0);
    step();                                   // ISSUE -> WAIT
    chk("wait_req",     {31'h0, mem_req_o},  32'h1);
    chk("wait_addr",    mem_addr_o,          32'h0);
    chk("wait_pcready", {31'h0, pc_ready_o}, 32'h0);
    start_i = 1'b0;
    step();                                   // still WAIT
    chk("wait2_req", {31'h0, mem_req_o}, 32'h1);
    mem_ack_i = 1'b1; mem_data_i = 32'h20080005;
    step();                                   // WAIT -> DELIVER
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    chk("del_instr",    instr_o,                32'h20080005);
    chk("del_valid",    {31'h0, instr_valid_o}, 32'h1);
    chk("del_pcready",  {31'h0, pc_ready_o},    32'h1);
    chk("del_req",      {31'h0, mem_req_o},     32'h0);
    chk("del_misalign", {31'h0, misalign_o},    32'h0);
    pc_i = 32'h4;
    step();                                   // DELIVER -> ISSUE
    chk("post_pcready", {31'h0, pc_ready_o},    32'h0);
    chk("post_valid",   {31'h0, instr_valid_o}, 32'h0);

    // Stall hold, ack in the first WAIT cycle.
    step();                                   // ISSUE -> WAIT
    chk("w4_addr", mem_addr_o, 32'h4);
    mem_ack_i = 1'b1; mem_data_i = 32'h11112222;
    step();                                   // WAIT -> DELIVER
    mem_ack_i = 1'b0; stall_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_instr",   instr_o,                32'h11112222);
      chk("stall_valid",   {31'h0, instr_valid_o}, 32'h1);
      chk("stall_pcready", {31'h0, pc_ready_o},    32'h0);
      if (i < 2) step();
    end
    stall_i = 1'b0; #1;
    chk("unstall_pcready", {31'h0, pc_ready_o}, 32'h1);
    pc_i = 32'h8;
    step();                                   // -> ISSUE
    step();                                   // -> WAIT
    chk("w8_addr", mem_addr_o, 32'h8);

    // Flush while waiting, ack two cycles later is discarded.
    flush_i = 1'b1; #1;
    chk("flushw_pcready", {31'h0, pc_ready_o}, 32'h1);
    step();
    flush_i = 1'b0; pc_i = 32'h20; #1;
    chk("flushw_pc0",   {31'h0, pc_ready_o}, 32'h0);
    chk("flushw_req",   {31'h0, mem_req_o},  32'h1);
    step();
    mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF; #1;
    chk("flushack_pcready", {31'h0, pc_ready_o}, 32'h0);
    step();                                   // discarded -> ISSUE
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    chk("flush_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("flush_req",   {31'h0, mem_req_o},     32'h0);
    step();                                   // -> WAIT with new pc
    chk("flush_newaddr", mem_addr_o,             32'h20);
    chk("flush_valid2",  {31'h0, instr_valid_o}, 32'h0);
    mem_ack_i = 1'b1; mem_data_i = 32'hAAAA0001;
    step();                                   // -> DELIVER
    mem_ack_i = 1'b0;
    chk("f20_instr", instr_o, 32'hAAAA0001);

    // Flush in DELIVER overrides stall.
    flush_i = 1'b1; stall_i = 1'b1; #1;
    chk("flushd_pcready", {31'h0, pc_ready_o}, 32'h1);
    step();                                   // -> ISSUE
    flush_i = 1'b0; stall_i = 1'b0;
    chk("flushd_valid", {31'h0, instr_valid_o}, 32'h0);

    // Misaligned PC delivers a NOP without a memory request.
    pc_i = 32'h6;
    step();                                   // ISSUE -> DELIVER
    chk("mis_req",      {31'h0, mem_req_o},     32'h0);
    chk("mis_instr",    instr_o,                32'h0);
    chk("mis_valid",    {31'h0, instr_valid_o}, 32'h1);
    chk("mis_misalign", {31'h0, misalign_o},    32'h1);
    chk("mis_pcready",  {31'h0, pc_ready_o},    32'h1);
    pc_i = 32'h10;
    step();                                   // -> ISSUE
    chk("mis_clear", {31'h0, misalign_o}, 32'h0);

    // Fetch 0x10 twice.
    step();                                   // -> WAIT
    chk("r1_req",  {31'h0, mem_req_o}, 32'h1);
    chk("r1_addr", mem_addr_o,          32'h10);
    mem_ack_i = 1'b1; mem_data_i = 32'h12345678;
    step();                                   // -> DELIVER
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    chk("r1_instr", instr_o, 32'h12345678);
    step();                                   // -> ISSUE
    step();
`ifdef IFETCH_REUSE_EN
    chk("r2_req",   {31'h0, mem_req_o},     32'h0);
    chk("r2_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("r2_instr", instr_o,                32'h12345678);
`else
    chk("r2_req",   {31'h0, mem_req_o},     32'h1);
    chk("r2_valid", {31'h0, instr_valid_o}, 32'h0);
    mem_ack_i = 1'b1; mem_data_i = 32'h12345678;
    step();
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    chk("r2_instr", instr_o, 32'h12345678);
`endif

    // Reset in the middle of WAIT; late ack in IDLE is ignored.
    pc_i = 32'h40;
    step();                                   // -> ISSUE
    step();                                   // -> WAIT
    chk("rw_req",  {31'h0, mem_req_o}, 32'h1);
    chk("rw_addr", mem_addr_o,          32'h40);
    rst_i = 1'b1;
    step();
    chk("rw_req0",  {31'h0, mem_req_o},     32'h0);
    chk("rw_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("rw_instr", instr_o,                32'h0);
    chk("rw_addr0", mem_addr_o,             32'h0);
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hCAFEF00D;
    step();
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    chk("late_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("late_req",   {31'h0, mem_req_o},     32'h0);
    chk("late_instr", instr_o,                32'h0);

    // After reset the reuse entry is gone: 0x10 must go to memory again.
    start_i = 1'b1; pc_i = 32'h10;
    step();                                   // -> ISSUE
    start_i = 1'b0;
    step();
    chk("postrst_req", {31'h0, mem_req_o}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
